// File: rtl/xseg_score_ctrl_pkg.sv
// Shared definitions for the seven-segment score controller.
// Covers register map, CMD bit positions, increment FSM states and segment constants.
package xseg_score_ctrl_pkg;

    localparam logic [1:0] ADDR_SCORE  = 2'd0;
    localparam logic [1:0] ADDR_CMD    = 2'd1;
    localparam logic [1:0] ADDR_DPMASK = 2'd2;

    // Bit positions inside a CMD write
    localparam int CMD_INC     = 0;
    localparam int CMD_CLR     = 1;
    localparam int CMD_BLANK   = 2;
    localparam int CMD_OVF_CLR = 3;

    // Bit positions inside a CMD read
    localparam int STAT_BLANK = 0;
    localparam int STAT_OVF   = 1;
    localparam int STAT_BUSY  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } inc_state_e;

    // Active-low segment patterns, bit order g..a
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/xseg_score_ctrl_if.sv
// Data-bus port of the score controller: the CPU side is the master,
// the score block the slave. Reads are combinational from addr.
interface xseg_score_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              sel;
    logic              we;
    logic [1:0]        addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (
        output sel,
        output we,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  sel,
        input  we,
        input  addr,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/xseg_decoder.sv
// Combinational BCD to seven-segment decoder, active-low, bit order g..a.
// Codes 10..15 are not BCD and show a dash.
module xseg_decoder
    import xseg_score_ctrl_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (digit_i)
            4'd0: seg_o = 7'h40;
            4'd1: seg_o = 7'h79;
            4'd2: seg_o = 7'h24;
            4'd3: seg_o = 7'h30;
            4'd4: seg_o = 7'h19;
            4'd5: seg_o = 7'h12;
            4'd6: seg_o = 7'h02;
            4'd7: seg_o = 7'h78;
            4'd8: seg_o = 7'h00;
            4'd9: seg_o = 7'h10;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/xseg_score_ctrl.sv
// Memory-mapped BCD score register with ripple increment FSM and multiplexed display scan.
// Optional XSEG_LEAD_ZERO_BLANK_EN darkens zero digits above the highest nonzero digit.
module xseg_score_ctrl
    import xseg_score_ctrl_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DATA_W      = 32,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    xseg_score_ctrl_if.slave    bus,
    output logic [DIGITS-1:0]   anode,
    output logic [7:0]          cathode,
    output logic                busy,
    output inc_state_e          dbg_state_o
);

    localparam int SCORE_W = 4 * DIGITS;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W   = $clog2(REFRESH_DIV);

    inc_state_e           state_q, state_d;
    logic [IDX_W-1:0]     dig_i_q, dig_i_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 ovf_q, ovf_d;
    logic                 blank_q, blank_d;
    logic [DIGITS-1:0]    dpmask_q, dpmask_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0]    anode_q, anode_d;
    logic [7:0]           cathode_q, cathode_d;

    logic                 wr_score, wr_cmd, wr_dp;
    logic                 cmd_inc, cmd_clr, cmd_ovf_clr;
    logic [IDX_W+1:0]     inc_off, scan_off;
    logic [3:0]           cur_digit, scan_digit;
    logic [6:0]           dec_seg, seg_show;
    logic                 unused_data;

    assign wr_score    = bus.sel && bus.we && (bus.addr == ADDR_SCORE);
    assign wr_cmd      = bus.sel && bus.we && (bus.addr == ADDR_CMD);
    assign wr_dp       = bus.sel && bus.we && (bus.addr == ADDR_DPMASK);
    assign cmd_inc     = wr_cmd && bus.data_in[CMD_INC];
    assign cmd_clr     = wr_cmd && bus.data_in[CMD_CLR];
    assign cmd_ovf_clr = wr_cmd && bus.data_in[CMD_OVF_CLR];
    assign unused_data = ^bus.data_in;

    assign inc_off   = {dig_i_q, 2'b00};
    assign cur_digit = score_q[inc_off +: 4];
    assign busy        = (state_q == ST_RUN);
    assign dbg_state_o = state_q;

    // Increment walks one digit per cycle from the LSD; CLR beats everything.
    always_comb begin
        state_d = state_q;
        dig_i_d = dig_i_q;
        score_d = score_q;
        ovf_d   = ovf_q && !cmd_ovf_clr;
        if (cmd_clr) begin
            score_d = '0;
            state_d = ST_IDLE;
            dig_i_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_score) begin
                        score_d = bus.data_in[SCORE_W-1:0];
                    end
                    if (cmd_inc) begin
                        state_d = ST_RUN;
                        dig_i_d = '0;
                    end
                end
                ST_RUN: begin
                    // Non-BCD digits behave as 9 so a corrupt score still rolls over.
                    if (cur_digit >= 4'd9) begin
                        score_d[inc_off +: 4] = 4'd0;
                        if (dig_i_q == IDX_W'(DIGITS - 1)) begin
                            ovf_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            dig_i_d = dig_i_q + IDX_W'(1);
                        end
                    end else begin
                        score_d[inc_off +: 4] = cur_digit + 4'd1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        blank_d  = blank_q;
        dpmask_d = dpmask_q;
        if (wr_cmd) begin
            blank_d = bus.data_in[CMD_BLANK];
        end
        if (wr_dp) begin
            dpmask_d = bus.data_in[DIGITS-1:0];
        end
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    assign scan_off   = {idx_q, 2'b00};
    assign scan_digit = score_q[scan_off +: 4];

    xseg_decoder u_dec (
        .digit_i (scan_digit),
        .seg_o   (dec_seg)
    );

`ifdef XSEG_LEAD_ZERO_BLANK_EN
    logic lead_zero;
    assign lead_zero = (idx_q != '0) && ((score_q >> scan_off) == '0);
    assign seg_show  = lead_zero ? SEG_OFF : dec_seg;
`else
    assign seg_show  = dec_seg;
`endif

    // Blanking only gates the anodes; the scan index keeps turning.
    always_comb begin
        anode_d   = blank_q ? '1 : ~(DIGITS'(1) << idx_q);
        cathode_d = {~dpmask_q[idx_q], seg_show};
    end

    always_comb begin
        bus.data_out = '0;
        if (bus.sel) begin
            case (bus.addr)
                ADDR_SCORE:  bus.data_out = DATA_W'(score_q);
                ADDR_CMD:    bus.data_out = DATA_W'({busy, ovf_q, blank_q});
                ADDR_DPMASK: bus.data_out = DATA_W'(dpmask_q);
                default:     bus.data_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dig_i_q   <= '0;
            score_q   <= '0;
            ovf_q     <= 1'b0;
            blank_q   <= 1'b0;
            dpmask_q  <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            anode_q   <= '1;
            cathode_q <= 8'hFF;
        end else begin
            state_q   <= state_d;
            dig_i_q   <= dig_i_d;
            score_q   <= score_d;
            ovf_q     <= ovf_d;
            blank_q   <= blank_d;
            dpmask_q  <= dpmask_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
        end
    end

    assign anode   = anode_q;
    assign cathode = cathode_q;

endmodule

// File: tb/tb_xseg_score_ctrl.sv
// Directed and randomized bench for xseg_score_ctrl (DIGITS=4, REFRESH_DIV=4).
// Honors XSEG_LEAD_ZERO_BLANK_EN when computing expected leading-zero display.
module tb_xseg_score_ctrl;
    import xseg_score_ctrl_pkg::*;

    localparam int D = 4;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [D-1:0] anode;
    logic [7:0]   cathode;
    logic         busy;
    inc_state_e   dbg_state;

    xseg_score_ctrl_if #(.DATA_W(32)) bus ();

    xseg_score_ctrl #(.DIGITS(D), .DATA_W(32), .REFRESH_DIV(R)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .anode       (anode),
        .cathode     (cathode),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge; the scan position follows from it.
    int t = 0;
    always @(posedge clk) begin
        if (rst) t <= 0;
        else     t <= t + 1;
    end

    int tests = 0;
    int fails = 0;

    logic [15:0] m_score = '0;
    logic [3:0]  m_dp    = '0;
    logic        m_blank = 1'b0;
    logic        m_ovf   = 1'b0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_in = d;
        @(negedge clk);
        bus.sel = 1'b0; bus.we = 1'b0; bus.data_in = '0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
        #1;
        d = bus.data_out;
        bus.sel = 1'b0;
    endtask

    // Counts negedges with busy high, starting at the current negedge.
    task automatic measure_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Expected cathode for a digit position from model state.
    function automatic logic [7:0] exp_cath(input int idx);
        logic [6:0] lit [16];
        logic [3:0] d;
        logic [6:0] seg;
        lit = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        d   = m_score[4*idx +: 4];
        seg = ~lit[d];
`ifdef XSEG_LEAD_ZERO_BLANK_EN
        if (idx > 0 && (m_score >> (4*idx)) == 16'h0) seg = 7'h7F;
`endif
        return {~m_dp[idx], seg};
    endfunction

    task automatic check_scan(input int n, input string tag);
        int idx;
        logic [3:0] exp_an;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            idx    = ((t - 1) / R) % D;
            exp_an = m_blank ? 4'hF : ~(4'b0001 << idx);
            check({tag, "_anode"}, 32'(anode), 32'(exp_an));
            if (!m_blank) check({tag, "_cathode"}, 32'(cathode), 32'(exp_cath(idx)));
        end
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] rd;
        read_reg(ADDR_SCORE, rd);
        check({tag, "_score"}, rd, 32'(m_score));
        read_reg(ADDR_CMD, rd);
        check({tag, "_cmd"}, rd, {29'd0, 1'b0, m_ovf, m_blank});
    endtask

    initial begin
        int n, v, tz, k, p, lat;
        logic [31:0] rd;
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_anode", 32'(anode), 32'hF);
        check("rst_cathode", 32'(cathode), 32'hFF);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_regs("rst");
        read_reg(ADDR_DPMASK, rd);
        check("rst_dpmask", rd, 32'h0);
        rst = 1'b0;

        // 0129 + 1: one trailing nine, two busy cycles
        write_reg(ADDR_SCORE, 32'h0129);
        write_reg(ADDR_CMD, 32'h1);
        check("t1_state_run", 32'(dbg_state), 32'(ST_RUN));
        measure_busy(n);
        check("t1_latency", 32'(n), 32'd2);
        m_score = 16'h0130;
        check_regs("t1");

        // All nines wraps with sticky overflow
        write_reg(ADDR_SCORE, 32'h9999);
        write_reg(ADDR_CMD, 32'h1);
        measure_busy(n);
        check("t2_latency", 32'(n), 32'd4);
        m_score = 16'h0000; m_ovf = 1'b1;
        check_regs("t2");
        write_reg(ADDR_CMD, 32'h8);
        m_ovf = 1'b0;
        check_regs("t2_ovfclr");

        // SCORE write during busy ignored, then CLR|INC aborts
        write_reg(ADDR_SCORE, 32'h9999);
        write_reg(ADDR_CMD, 32'h1);
        write_reg(ADDR_SCORE, 32'h1234);
        write_reg(ADDR_CMD, 32'h3);
        check("t3_busy_after_clr", 32'(busy), 32'h0);
        m_score = 16'h0000;
        check_regs("t3");

        // SCORE write mid-increment must not disturb the result
        write_reg(ADDR_SCORE, 32'h0999);
        write_reg(ADDR_CMD, 32'h1);
        write_reg(ADDR_SCORE, 32'h1234);
        measure_busy(n);
        m_score = 16'h1000;
        check_regs("t3_ign_score");

        // Second INC while busy is ignored
        write_reg(ADDR_SCORE, 32'h0199);
        write_reg(ADDR_CMD, 32'h1);
        write_reg(ADDR_CMD, 32'h1);
        measure_busy(n);
        m_score = 16'h0200;
        check_regs("t3_ign_inc");

        // Non-BCD digit counts as nine
        write_reg(ADDR_SCORE, 32'h00A9);
        write_reg(ADDR_CMD, 32'h1);
        measure_busy(n);
        check("inv_latency", 32'(n), 32'd3);
        m_score = 16'h0100;
        check_regs("inv");

        // Random valid scores against decimal arithmetic
        for (int it = 0; it < 10; it++) begin
            v  = $urandom_range(0, 9999);
            tz = $urandom_range(0, 4);
            p  = 1;
            for (int j = 0; j < tz; j++) p = p * 10;
            v = (v / p) * p + (p - 1);
            k = 0;
            for (int x = v; k < D && x % 10 == 9; x = x / 10) k++;
            lat = (k >= D) ? D : k + 1;
            write_reg(ADDR_SCORE, 32'(to_bcd(v)));
            write_reg(ADDR_CMD, 32'h1);
            measure_busy(n);
            check("rnd_latency", 32'(n), 32'(lat));
            m_score = to_bcd((v + 1) % 10000);
            if (v == 9999) m_ovf = 1'b1;
            check_regs("rnd");
            if ($urandom_range(0, 1) == 1) begin
                write_reg(ADDR_CMD, 32'h8);
                m_ovf = 1'b0;
            end
        end
        write_reg(ADDR_CMD, 32'h8);
        m_ovf = 1'b0;

        // Scan of 0042 with dp on digit 1
        write_reg(ADDR_SCORE, 32'h0042);
        m_score = 16'h0042;
        write_reg(ADDR_DPMASK, 32'h2);
        m_dp = 4'b0010;
        read_reg(ADDR_DPMASK, rd);
        check("dpmask_rd", rd, 32'h2);
        check_scan(20, "scan42");

        // Random raw scores and masks on the display
        for (int it = 0; it < 3; it++) begin
            m_score = 16'($urandom_range(0, 65535));
            m_dp    = 4'($urandom_range(0, 15));
            write_reg(ADDR_SCORE, 32'(m_score));
            write_reg(ADDR_DPMASK, 32'(m_dp));
            check_scan(16, "scan_rnd");
        end

        // Dash for non-BCD digit, then blanking while scan advances
        write_reg(ADDR_DPMASK, 32'h2);
        m_dp = 4'b0010;
        write_reg(ADDR_SCORE, 32'h00A5);
        m_score = 16'h00A5;
        check_scan(16, "scan_dash");
        write_reg(ADDR_CMD, 32'h4);
        m_blank = 1'b1;
        check_regs("blank");
        check_scan(10, "scan_blank");
        write_reg(ADDR_CMD, 32'h0);
        m_blank = 1'b0;
        check_scan(8, "scan_unblank");

        // Reset mid-increment
        write_reg(ADDR_SCORE, 32'h9999);
        write_reg(ADDR_CMD, 32'h1);
        check("t6_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        m_score = '0; m_dp = '0; m_blank = 1'b0; m_ovf = 1'b0;
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
        check("t6_anode", 32'(anode), 32'hF);
        check("t6_cathode", 32'(cathode), 32'hFF);
        check_regs("t6");
        rst = 1'b0;
        check_scan(8, "scan_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
